fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline buffer: owns the PC, drives a

---
 rtl/pipe_pkg.sv | 11 +
 rtl/fetch_pc_reg.sv | 28 ++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, NOP encoding and fetch FSM states
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 16;
  localparam int unsigned PIPE_ADDR_W = 16;
  localparam logic [PIPE_DATA_W-1:0] PIPE_NOP = 16'h0000;

  localparam logic [0:0] FETCH_RUN  = 1'b0;
  localparam logic [0:0] FETCH_HOLD = 1'b1;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with reset, load, increment and hold
module fetch_pc_reg
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W   = PIPE_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned PC_INC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // Addition truncates to ADDR_W, so the PC wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + ADDR_W'(PC_INC);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with stall skid register and redirect squash
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = PIPE_DATA_W,
  parameter int unsigned ADDR_W   = PIPE_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned PC_INC   = 1,
  parameter logic [DATA_W-1:0] NOP      = PIPE_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_rd_o,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_o,
  output logic              valid_o
);

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              req_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic [DATA_W-1:0] hold_q;
  logic [ADDR_W-1:0] hold_pc_q;
  logic              hold_v_q;

  logic              issue;
  logic              from_hold;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_instr;
  logic [ADDR_W-1:0] sel_pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect_i),
    .load_pc (redirect_pc_i),
    .inc     (issue),
    .pc      (pc_q)
  );

  assign issue       = !rst && !redirect_i && !stall_i;
  assign imem_rd_o   = issue;
  assign imem_addr_o = pc_q;

  // While holding, the buffer still sees the word captured when the stall began.
  assign from_hold = (state_q == FETCH_HOLD);
  assign sel_valid = from_hold ? hold_v_q  : req_q;
  assign sel_instr = from_hold ? hold_q    : imem_data_i;
  assign sel_pc    = from_hold ? hold_pc_q : req_pc_q;

  assign valid_o   = sel_valid && !rst && !redirect_i;
  assign instr_o   = valid_o ? sel_instr : NOP;
  assign pc_o      = valid_o ? sel_pc : '0;
  assign pc_plus_o = pc_o + ADDR_W'(PC_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_RUN;
      req_q     <= 1'b0;
      req_pc_q  <= '0;
      hold_q    <= NOP;
      hold_pc_q <= '0;
      hold_v_q  <= 1'b0;
    end else if (redirect_i) begin
      state_q  <= FETCH_RUN;
      req_q    <= 1'b0;
      hold_v_q <= 1'b0;
    end else if (stall_i) begin
      req_q <= 1'b0;
      // Capture only on stall entry; later stall cycles see no fresh memory data.
      if (state_q == FETCH_RUN) begin
        hold_q    <= imem_data_i;
        hold_pc_q <= req_pc_q;
        hold_v_q  <= req_q;
        state_q   <= FETCH_HOLD;
      end
    end else begin
      state_q  <= FETCH_RUN;
      req_q    <= 1'b1;
      req_pc_q <= pc_q;
      hold_v_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_data, instr, pc, pc_plus;
  logic        imem_rd, valid;

  logic        rst_w;
  logic [15:0] imem_addr_w, imem_data_w, instr_w, pc_w, pc_plus_w;
  logic        imem_rd_w, valid_w;

  int n_cmp = 0;
  int n_fail = 0;

  logic [48:0] obs, obs_w;
  logic [16:0] obs_v, rd_obs, rd_obs_w;

  assign obs      = {valid, instr, pc, pc_plus};
  assign obs_v    = {valid, instr};
  assign rd_obs   = {imem_rd, imem_addr};
  assign obs_w    = {valid_w, instr_w, pc_w, pc_plus_w};
  assign rd_obs_w = {imem_rd_w, imem_addr_w};

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_rd_o     (imem_rd),
    .imem_data_i   (imem_data),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus_o     (pc_plus),
    .valid_o       (valid)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk           (clk),
    .rst           (rst_w),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (16'h0000),
    .imem_addr_o   (imem_addr_w),
    .imem_rd_o     (imem_rd_w),
    .imem_data_i   (imem_data_w),
    .instr_o       (instr_w),
    .pc_o          (pc_w),
    .pc_plus_o     (pc_plus_w),
    .valid_o       (valid_w)
  );

  // Memory model: mem[a] = A000 + a[11:0], one-cycle read latency.
  always @(posedge clk) begin
    if (imem_rd)   imem_data   <= 16'hA000 + {4'h0, imem_addr[11:0]};
    if (imem_rd_w) imem_data_w <= 16'hA000 + {4'h0, imem_addr_w[11:0]};
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; rst_w = 1'b1;
    imem_data = 16'h0000; imem_data_w = 16'h0000;
    step(); #1;
    n_cmp++; if ({obs_v, pc} !== {1'b0, 16'h0000, 16'h0000}) begin n_fail++; $display("FAIL reset_out: got %h want %h", {obs_v, pc}, 33'h0); end
    n_cmp++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", imem_rd); end
    step(); #1;
    n_cmp++; if ({obs_v, pc} !== {1'b0, 16'h0000, 16'h0000}) begin n_fail++; $display("FAIL reset_out2: got %h want %h", {obs_v, pc}, 33'h0); end
    step(); rst = 1'b0; #1;
    n_cmp++; if ({obs_v, pc} !== {1'b0, 16'h0000, 16'h0000}) begin n_fail++; $display("FAIL post_reset_out: got %h want %h", {obs_v, pc}, 33'h0); end
    n_cmp++; if (rd_obs !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL post_reset_rd: got %h want %h", rd_obs, 17'h10000); end
  endtask

  task automatic test_stream();
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA000, 16'h0000, 16'h0001}) begin n_fail++; $display("FAIL stream_0: got %h want %h", obs, {1'b1, 16'hA000, 16'h0000, 16'h0001}); end
    n_cmp++; if (rd_obs !== {1'b1, 16'h0001}) begin n_fail++; $display("FAIL stream_rd1: got %h want %h", rd_obs, {1'b1, 16'h0001}); end
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA001, 16'h0001, 16'h0002}) begin n_fail++; $display("FAIL stream_1: got %h want %h", obs, {1'b1, 16'hA001, 16'h0001, 16'h0002}); end
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA002, 16'h0002, 16'h0003}) begin n_fail++; $display("FAIL stream_2: got %h want %h", obs, {1'b1, 16'hA002, 16'h0002, 16'h0003}); end
  endtask

  task automatic test_stall();
    step(); stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin step(); #1; end
      n_cmp++; if (obs !== {1'b1, 16'hA003, 16'h0003, 16'h0004}) begin n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, {1'b1, 16'hA003, 16'h0003, 16'h0004}); end
      n_cmp++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL stall_rd%0d: got %b want 0", i, imem_rd); end
    end
    step(); stall = 1'b0; #1;
    n_cmp++; if (obs !== {1'b1, 16'hA003, 16'h0003, 16'h0004}) begin n_fail++; $display("FAIL stall_release: got %h want %h", obs, {1'b1, 16'hA003, 16'h0003, 16'h0004}); end
    n_cmp++; if (rd_obs !== {1'b1, 16'h0004}) begin n_fail++; $display("FAIL stall_release_rd: got %h want %h", rd_obs, {1'b1, 16'h0004}); end
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA004, 16'h0004, 16'h0005}) begin n_fail++; $display("FAIL stall_after0: got %h want %h", obs, {1'b1, 16'hA004, 16'h0004, 16'h0005}); end
  endtask

  task automatic test_redirect();
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA005, 16'h0005, 16'h0006}) begin n_fail++; $display("FAIL stall_after1: got %h want %h", obs, {1'b1, 16'hA005, 16'h0005, 16'h0006}); end
    redirect = 1'b1; redirect_pc = 16'h0040; #1;
    n_cmp++; if ({obs_v, imem_rd} !== {1'b0, 16'h0000, 1'b0}) begin n_fail++; $display("FAIL redir_cycle: got %h want %h", {obs_v, imem_rd}, 18'h0); end
    step(); redirect = 1'b0; #1;
    n_cmp++; if (obs_v !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL redir_bubble: got %h want %h", obs_v, 17'h0); end
    n_cmp++; if (rd_obs !== {1'b1, 16'h0040}) begin n_fail++; $display("FAIL redir_rd: got %h want %h", rd_obs, {1'b1, 16'h0040}); end
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA040, 16'h0040, 16'h0041}) begin n_fail++; $display("FAIL redir_t0: got %h want %h", obs, {1'b1, 16'hA040, 16'h0040, 16'h0041}); end
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA041, 16'h0041, 16'h0042}) begin n_fail++; $display("FAIL redir_t1: got %h want %h", obs, {1'b1, 16'hA041, 16'h0041, 16'h0042}); end
  endtask

  task automatic test_redirect_in_hold();
    step(); stall = 1'b1; #1;
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA042, 16'h0042, 16'h0043}) begin n_fail++; $display("FAIL hold_pre_redir: got %h want %h", obs, {1'b1, 16'hA042, 16'h0042, 16'h0043}); end
    redirect = 1'b1; redirect_pc = 16'h0040; #1;
    n_cmp++; if ({obs_v, imem_rd} !== {1'b0, 16'h0000, 1'b0}) begin n_fail++; $display("FAIL hold_redir_cycle: got %h want %h", {obs_v, imem_rd}, 18'h0); end
    step(); redirect = 1'b0; stall = 1'b0; #1;
    n_cmp++; if (obs_v !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL hold_discarded: got %h want %h", obs_v, 17'h0); end
    n_cmp++; if (rd_obs !== {1'b1, 16'h0040}) begin n_fail++; $display("FAIL hold_redir_rd: got %h want %h", rd_obs, {1'b1, 16'h0040}); end
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA040, 16'h0040, 16'h0041}) begin n_fail++; $display("FAIL hold_redir_t0: got %h want %h", obs, {1'b1, 16'hA040, 16'h0040, 16'h0041}); end
  endtask

  task automatic test_reset_in_hold();
    step(); stall = 1'b1; #1;
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA041, 16'h0041, 16'h0042}) begin n_fail++; $display("FAIL rhold_pre: got %h want %h", obs, {1'b1, 16'hA041, 16'h0041, 16'h0042}); end
    rst = 1'b1; #1;
    n_cmp++; if ({obs_v, imem_rd} !== {1'b0, 16'h0000, 1'b0}) begin n_fail++; $display("FAIL rhold_rst0: got %h want %h", {obs_v, imem_rd}, 18'h0); end
    step(); #1;
    n_cmp++; if ({obs_v, imem_rd} !== {1'b0, 16'h0000, 1'b0}) begin n_fail++; $display("FAIL rhold_rst1: got %h want %h", {obs_v, imem_rd}, 18'h0); end
    step(); rst = 1'b0; stall = 1'b0; #1;
    n_cmp++; if (obs_v !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL rhold_after: got %h want %h", obs_v, 17'h0); end
    n_cmp++; if (rd_obs !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL rhold_rd: got %h want %h", rd_obs, 17'h10000); end
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA000, 16'h0000, 16'h0001}) begin n_fail++; $display("FAIL rhold_t0: got %h want %h", obs, {1'b1, 16'hA000, 16'h0000, 16'h0001}); end
    step(); #1;
    n_cmp++; if (obs !== {1'b1, 16'hA001, 16'h0001, 16'h0002}) begin n_fail++; $display("FAIL rhold_t1: got %h want %h", obs, {1'b1, 16'hA001, 16'h0001, 16'h0002}); end
  endtask

  task automatic test_wrap();
    step(); rst_w = 1'b0; #1;
    n_cmp++; if ({valid_w, instr_w} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL wrap_first: got %h want %h", {valid_w, instr_w}, 17'h0); end
    n_cmp++; if (rd_obs_w !== {1'b1, 16'hFFFE}) begin n_fail++; $display("FAIL wrap_rd: got %h want %h", rd_obs_w, {1'b1, 16'hFFFE}); end
    step(); #1;
    n_cmp++; if (obs_w !== {1'b1, 16'hAFFE, 16'hFFFE, 16'hFFFF}) begin n_fail++; $display("FAIL wrap_0: got %h want %h", obs_w, {1'b1, 16'hAFFE, 16'hFFFE, 16'hFFFF}); end
    step(); #1;
    n_cmp++; if (obs_w !== {1'b1, 16'hAFFF, 16'hFFFF, 16'h0000}) begin n_fail++; $display("FAIL wrap_1: got %h want %h", obs_w, {1'b1, 16'hAFFF, 16'hFFFF, 16'h0000}); end
    step(); #1;
    n_cmp++; if (obs_w !== {1'b1, 16'hA000, 16'h0000, 16'h0001}) begin n_fail++; $display("FAIL wrap_2: got %h want %h", obs_w, {1'b1, 16'hA000, 16'h0000, 16'h0001}); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_in_hold();
    test_reset_in_hold();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
